// File: rtl/seq_div_32.sv
// Restoring divider, one quotient bit per clock: DONE pulses WIDTH+1 edges after an accepted START, or 1 edge for B==0 or signed overflow.
// No backpressure: while BUSY is high, START is ignored, and the caller stalls on BUSY/DONE.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV0,
    output logic             OVF
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             div0_pnd_q, div0_pnd_d;
    logic             ovf_pnd_q, ovf_pnd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             a_neg, b_neg, b_zero, ovf_case;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   trial;

    always_comb begin
        a_neg    = SIGNED & A[WIDTH-1];
        b_neg    = SIGNED & B[WIDTH-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        b_zero   = (B == '0);
        ovf_case = SIGNED && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        // One extra bit so a shifted remainder that spills past WIDTH still compares correctly.
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        div0_pnd_d = div0_pnd_q;
        ovf_pnd_d  = ovf_pnd_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        q_d        = q_q;
        r_d        = r_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    busy_d     = 1'b1;
                    div0_d     = 1'b0;
                    ovf_d      = 1'b0;
                    div0_pnd_d = 1'b0;
                    ovf_pnd_d  = 1'b0;
                    qneg_d     = a_neg ^ b_neg;
                    rneg_d     = a_neg;
                    quo_d      = a_mag;
                    rem_d      = '0;
                    dvs_d      = b_mag;
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = S_CALC;
                    // Degenerate cases preload the final raw result and skip iteration.
                    if (b_zero) begin
                        quo_d      = '1;
                        rem_d      = A;
                        qneg_d     = 1'b0;
                        rneg_d     = 1'b0;
                        div0_pnd_d = 1'b1;
                        state_d    = S_FIX;
                    end else if (ovf_case) begin
                        quo_d     = A;
                        rem_d     = '0;
                        qneg_d    = 1'b0;
                        rneg_d    = 1'b0;
                        ovf_pnd_d = 1'b1;
                        state_d   = S_FIX;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                q_d     = qneg_q ? -quo_q : quo_q;
                r_d     = rneg_q ? -rem_q : rem_q;
                div0_d  = div0_pnd_q;
                ovf_d   = ovf_pnd_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            div0_pnd_q <= 1'b0;
            ovf_pnd_q  <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            div0_pnd_q <= div0_pnd_d;
            ovf_pnd_q  <= ovf_pnd_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            q_q        <= q_d;
            r_q        <= r_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign DIV0 = div0_q;
    assign OVF  = ovf_q;
endmodule

// File: tb/tb_seq_div_32.sv
// Bench for seq_div_32: directed corner cases plus randomized operations checked against a plain-arithmetic model.
module tb_seq_div_32;
    logic        CLK, RESET_N, START, SIGNED;
    logic [31:0] A, B, Q, R;
    logic        BUSY, DONE, DIV0, OVF;
    int          total, passed;

    seq_div_32 #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SIGNED(SIGNED),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R),
        .DIV0(DIV0), .OVF(OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic d0, output logic ov);
        int sa, sb;
        d0 = 1'b0;
        ov = 1'b0;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; d0 = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; ov = 1'b1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Operands are scrambled right after acceptance to prove the in-flight result is isolated.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge CLK);
        A = a; B = b; SIGNED = s; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0; A = $urandom; B = $urandom; SIGNED = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end while (!DONE && lat < 100);
    endtask

    task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic ed0,
                          input logic eov, input int elat);
        int lat;
        start_op(a, b, s);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, Q, eq);
        chk({tag, "_r"}, R, er);
        chk({tag, "_div0"}, 32'(DIV0), 32'(ed0));
        chk({tag, "_ovf"}, 32'(OVF), 32'(eov));
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int          lat, dn;
        logic [31:0] ra, rb, eq, er;
        logic        rs, ed0, eov;
        total = 0; passed = 0;
        RESET_N = 1'b0; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_q", Q, 32'd0);
        chk("rst_r", R, 32'd0);
        chk("rst_div0", 32'(DIV0), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        RESET_N = 1'b1;

        op_chk("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 33);
        op_chk("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        op_chk("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33);
        op_chk("div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1);
        op_chk("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1);
        op_chk("uovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33);
        op_chk("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33);
        op_chk("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, 33);

        start_op(32'd100, 32'd7, 1'b0);
        repeat (3) begin
            @(negedge CLK); START = 1'b1; A = 32'd1000; B = 32'd3;
            @(negedge CLK); START = 1'b0;
        end
        wait_done(lat);
        chk("ign_done", 32'(DONE), 32'd1);
        chk("ign_q", Q, 32'd14);
        chk("ign_r", R, 32'd2);

        @(negedge CLK); START = 1'b1; A = 32'd20; B = 32'd3; SIGNED = 1'b0;
        @(posedge CLK); #1;
        wait_done(lat);
        chk("held1_lat", 32'(lat), 32'd33);
        chk("held1_q", Q, 32'd6);
        @(negedge CLK);
        chk("held_reaccept_busy", 32'(BUSY), 32'd1);
        chk("held_done_pulse", 32'(DONE), 32'd0);
        START = 1'b0;
        wait_done(lat);
        chk("held2_lat", 32'(lat), 32'd33);
        chk("held2_r", R, 32'd2);

        start_op(32'd999, 32'd10, 1'b0);
        repeat (9) @(posedge CLK);
        @(negedge CLK); RESET_N = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_q", Q, 32'd0);
        chk("abort_r", R, 32'd0);
        @(negedge CLK); RESET_N = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_idle", 32'(BUSY), 32'd0);

        for (int i = 0; i < 1200; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            ref_div(ra, rb, rs, eq, er, ed0, eov);
            op_chk("rnd", ra, rb, rs, eq, er, ed0, eov, (ed0 || eov) ? 1 : 33);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
